// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard receive controller for the CPLD I/O window.
// Conditions KB_CLK/KB_DATA, captures 11-bit frames with a start/data/parity/stop
// FSM guarded by a watchdog, buffers good scan codes in a FIFO and serves the
// DATA/STATUS registers to the CPU read path.
module ps2_kb_controller #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KB_CLK,
  input  logic       KB_DATA,
  input  logic       RD_STB,
  input  logic       ADDR0,
  output logic [7:0] DOUT,
  output logic       IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity over data plus parity bit: a good frame has an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic             filt_clk_r;
  logic [FLT_W-1:0] filt_cnt_r;
  logic             filt_change_s, fall_s;
  state_t           state_r, state_next_s;
  logic [2:0]       bitcnt_r;
  logic [7:0]       shift_r;
  logic             parity_ok_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic             timeout_s;
  logic             push_req_s, perr_set_s, ferr_set_s, to_set_s;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             full_s, rxav_s, pop_s, push_ok_s, ovf_set_s, status_rd_s;
  logic             to_r, ferr_r, perr_r, ovf_r;
  logic             to_next_s, ferr_next_s, perr_next_s, ovf_next_s;
  logic [7:0]       status_s, read_data_s;

  // Two-flop synchronisers, reset high so reset release never looks like a falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= KB_CLK;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= KB_DATA;
      data_sync_r <= data_meta_r;
    end
  end

  // The filtered clock flips only on the FILTER_LEN-th consecutive differing sample.
  assign filt_change_s = (clk_sync_r != filt_clk_r) && (filt_cnt_r == FLT_W'(FILTER_LEN - 1));
  assign fall_s        = filt_change_s & filt_clk_r;

  // Glitch filter on the synchronised PS/2 clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_clk_r <= 1'b1;
      filt_cnt_r <= FLT_W'(0);
    end else if (clk_sync_r == filt_clk_r) begin
      filt_cnt_r <= FLT_W'(0);
    end else if (filt_change_s) begin
      filt_clk_r <= clk_sync_r;
      filt_cnt_r <= FLT_W'(0);
    end else begin
      filt_cnt_r <= filt_cnt_r + FLT_W'(1);
    end
  end

  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (wd_cnt_r == WD_W'(TIMEOUT - 1));

  // Watchdog: measures the gap between falling edges while a frame is in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt_r <= WD_W'(0);
    end else if ((state_r == ST_IDLE) || fall_s || timeout_s) begin
      wd_cnt_r <= WD_W'(0);
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame FSM next state: advances on fall events, aborts to IDLE on watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    if (timeout_s) begin
      state_next_s = ST_IDLE;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE:   state_next_s = data_sync_r ? ST_IDLE : ST_DATA;
        ST_DATA:   state_next_s = (bitcnt_r == 3'd7) ? ST_PARITY : ST_DATA;
        ST_PARITY: state_next_s = ST_STOP;
        ST_STOP:   state_next_s = ST_IDLE;
        default:   state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame FSM outputs: push / error strobes produced at the stop-bit fall event.
  always_comb begin
    push_req_s = 1'b0;
    perr_set_s = 1'b0;
    ferr_set_s = 1'b0;
    to_set_s   = timeout_s;
    if (fall_s && (state_r == ST_STOP)) begin
      push_req_s = parity_ok_r & data_sync_r;
      perr_set_s = ~parity_ok_r;
      ferr_set_s = ~data_sync_r;
    end else begin
      push_req_s = 1'b0;
    end
  end

  // Frame datapath: bit counter, LSB-first shifter and parity result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bitcnt_r    <= 3'd0;
      shift_r     <= 8'h00;
      parity_ok_r <= 1'b0;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE:   bitcnt_r <= 3'd0;
        ST_DATA: begin
          shift_r  <= {data_sync_r, shift_r[7:1]};
          bitcnt_r <= bitcnt_r + 3'd1;
        end
        ST_PARITY: parity_ok_r <= odd_parity(shift_r, data_sync_r);
        default:   bitcnt_r <= bitcnt_r;
      endcase
    end else begin
      bitcnt_r <= bitcnt_r;
    end
  end

  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign rxav_s      = (count_r != CNT_W'(0));
  assign pop_s       = RD_STB & ~ADDR0 & rxav_s;
  assign status_rd_s = RD_STB & ADDR0;
  assign push_ok_s   = push_req_s & (~full_s | pop_s);
  assign ovf_set_s   = push_req_s & full_s & ~pop_s;
  assign to_next_s   = to_set_s   | (to_r   & ~status_rd_s);
  assign ferr_next_s = ferr_set_s | (ferr_r & ~status_rd_s);
  assign perr_next_s = perr_set_s | (perr_r & ~status_rd_s);
  assign ovf_next_s  = ovf_set_s  | (ovf_r  & ~status_rd_s);
  assign status_s    = {2'b00, to_r, ferr_r, perr_r, ovf_r, full_s, rxav_s};
  assign read_data_s = ADDR0 ? status_s : (rxav_s ? mem_r[rd_ptr_r] : 8'h00);

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Scan-code FIFO storage and pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Sticky flags, registered read data and interrupt request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_r   <= 1'b0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      ovf_r  <= 1'b0;
      DOUT   <= 8'h00;
      IRQ    <= 1'b0;
    end else begin
      to_r   <= to_next_s;
      ferr_r <= ferr_next_s;
      perr_r <= perr_next_s;
      ovf_r  <= ovf_next_s;
      DOUT   <= RD_STB ? read_data_s : DOUT;
      IRQ    <= (count_next_s != CNT_W'(0)) | ovf_next_s | perr_next_s | ferr_next_s | to_next_s;
    end
  end

endmodule

// File: tb/tb_ps2_kb_controller.sv
// Self-checking bench for ps2_kb_controller. CLK is modelled as 1 MHz, so an
// 80-cycle PS/2 period corresponds to 12.5 kHz. The reference model is a byte
// queue plus four sticky flags updated from whole-frame rules.
module tb_ps2_kb_controller;

  localparam int DEPTH = 8;
  localparam int TMO   = 256;
  localparam int HALF  = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KB_CLK = 1'b1;
  logic       KB_DATA = 1'b1;
  logic       RD_STB = 1'b0;
  logic       ADDR0 = 1'b0;
  logic [7:0] DOUT;
  logic       IRQ;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit m_to, m_ferr, m_perr, m_ovf;

  ps2_kb_controller #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA),
    .RD_STB(RD_STB), .ADDR0(ADDR0), .DOUT(DOUT), .IRQ(IRQ)
  );

  always #500 CLK = ~CLK;

  function automatic logic [7:0] exp_status();
    return {2'b00, m_to, m_ferr, m_perr, m_ovf, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  function automatic logic exp_irq();
    return (mq.size() != 0) | m_to | m_ferr | m_perr | m_ovf;
  endfunction

  function automatic logic [7:0] model_status_read();
    logic [7:0] v;
    v = exp_status();
    m_to = 0; m_ferr = 0; m_perr = 0; m_ovf = 0;
    return v;
  endfunction

  function automatic logic [7:0] model_data_read();
    if (mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_to = 0; m_ferr = 0; m_perr = 0; m_ovf = 0;
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge CLK); KB_DATA = b;
    repeat (HALF / 2) @(negedge CLK);
    KB_CLK = 1'b0;
    repeat (HALF) @(negedge CLK);
    KB_CLK = 1'b1;
    repeat (HALF / 2) @(negedge CLK);
  endtask

  // Sends one frame; parity is odd unless bad_par, stop is 1 unless bad_stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    bit ok_par;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    par = par ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    KB_DATA = 1'b1;
    repeat (10) @(negedge CLK);
    ok_par = ((($countones(b) + (par ? 1 : 0)) % 2) == 1);
    if (ok_par && !bad_stop) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1;
    end else begin
      if (!ok_par) m_perr = 1;
      if (bad_stop) m_ferr = 1;
    end
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    @(negedge CLK); RD_STB = 1'b1; ADDR0 = a;
    @(negedge CLK); RD_STB = 1'b0; ADDR0 = 1'b0;
    d = DOUT;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    n_checks++;
    if (DOUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", DOUT); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, e); end
  endtask

  task automatic test_single();
    logic [7:0] d, e;
    send_frame(8'h1C, 0, 0);
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL single_irq_set: got %b want 1", IRQ); end
    rd(1'b0, d); e = model_data_read();
    n_checks++;
    if (d !== e || d !== 8'h1C) begin n_fail++; $display("FAIL single_data: got %h want %h", d, e); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL single_irq_clr: got %b want 0", IRQ); end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL single_status: got %h want %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = model_data_read(); rd(1'b0, d);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, d, e); end
    end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e || d !== 8'h00) begin n_fail++; $display("FAIL b2b_status: got %h want %h", d, e); end
  endtask

  task automatic test_overflow();
    logic [7:0] d, e;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e || d !== 8'h07) begin n_fail++; $display("FAIL ovf_status: got %h want %h", d, e); end
    e = model_data_read(); rd(1'b0, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL ovf_first: got %h want %h", d, e); end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e || d !== 8'h01) begin n_fail++; $display("FAIL ovf_status2: got %h want %h", d, e); end
    for (int i = 0; i < 8; i++) begin
      e = model_data_read(); rd(1'b0, d);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_errors();
    logic [7:0] d, e;
    logic [7:0] want [3] = '{8'h08, 8'h10, 8'h18};
    for (int k = 0; k < 3; k++) begin
      send_frame(8'h1C, k != 1, k != 0);
      n_checks++;
      if (IRQ !== exp_irq()) begin n_fail++; $display("FAIL err_irq%0d: got %b want %b", k, IRQ, exp_irq()); end
      e = model_status_read(); rd(1'b1, d);
      n_checks++;
      if (d !== e || d !== want[k]) begin n_fail++; $display("FAIL err_status%0d: got %h want %h", k, d, e); end
      e = model_status_read(); rd(1'b1, d);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL err_clear%0d: got %h want %h", k, d, e); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d, e;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge CLK);
    m_to = 1;
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL to_irq: got %b want 1", IRQ); end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e || d !== 8'h20) begin n_fail++; $display("FAIL to_status: got %h want %h", d, e); end
    send_frame(8'h5A, 0, 0);
    e = model_data_read(); rd(1'b0, d);
    n_checks++;
    if (d !== e || d !== 8'h5A) begin n_fail++; $display("FAIL to_recover: got %h want %h", d, e); end
  endtask

  task automatic test_glitch_reset();
    logic [7:0] d, e;
    @(negedge CLK); KB_DATA = 1'b0; KB_CLK = 1'b0;
    repeat (2) @(negedge CLK);
    KB_CLK = 1'b1; KB_DATA = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h33, 0, 0);
    e = model_data_read(); rd(1'b0, d);
    n_checks++;
    if (d !== e || d !== 8'h33) begin n_fail++; $display("FAIL glitch_data: got %h want %h", d, e); end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL glitch_status: got %h want %h", d, e); end
    send_frame(8'h44, 0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    @(negedge CLK); RST = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (DOUT !== 8'h00 || IRQ !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got dout=%h irq=%b want 00/0", DOUT, IRQ); end
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e || d !== 8'h00) begin n_fail++; $display("FAIL midreset_empty: got %h want %h", d, e); end
    send_frame(8'hA7, 0, 0);
    e = model_data_read(); rd(1'b0, d);
    n_checks++;
    if (d !== e || d !== 8'hA7) begin n_fail++; $display("FAIL midreset_next: got %h want %h", d, e); end
  endtask

  task automatic test_random();
    logic [7:0] d, e, b;
    int sel, r;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 7);
      send_frame(b, sel == 0, sel == 1);
      n_checks++;
      if (IRQ !== exp_irq()) begin n_fail++; $display("FAIL rnd_irq%0d: got %b want %b", k, IRQ, exp_irq()); end
      r = $urandom_range(0, 3);
      if (r == 1 || r == 3) begin
        e = model_data_read(); rd(1'b0, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL rnd_data%0d: got %h want %h", k, d, e); end
      end
      if (r >= 2) begin
        e = model_status_read(); rd(1'b1, d);
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL rnd_status%0d: got %h want %h", k, d, e); end
      end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      e = model_data_read(); rd(1'b0, d);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL rnd_drain%0d: got %h want %h", i, d, e); end
    end
    e = model_status_read(); rd(1'b1, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL rnd_final_status: got %h want %h", d, e); end
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_timeout();
    test_glitch_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
